// File: rtl/gfx_pkg.sv
// Shared definitions for the line rasterizer: default width, FSM encoding
// and the minor-axis step constants.
package gfx_pkg;

  localparam int GFX_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

  localparam logic signed [1:0] YSTEP_POS = 2'sb01;
  localparam logic signed [1:0] YSTEP_NEG = 2'sb11;

endpackage

// File: rtl/Precomputed_param.sv
// Combinational Bresenham setup: picks the major axis, orders the endpoints
// along it and derives the deltas and minor-axis step direction.
module Precomputed_param
  import gfx_pkg::*;
#(
  parameter int WIDTH = GFX_WIDTH
) (
  input  logic [WIDTH-1:0]  x0,
  input  logic [WIDTH-1:0]  y0,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  x0_out,
  output logic [WIDTH-1:0]  x1_out,
  output logic [WIDTH-1:0]  y0_out,
  output logic [WIDTH-1:0]  deltax,
  output logic [WIDTH-1:0]  deltay,
  output logic signed [1:0] ystep,
  output logic              steep
);

  logic signed [WIDTH-1:0] dx_raw, dy_raw, abs_dx, abs_dy;
  logic signed [WIDTH-1:0] sa0, sb0, sa1, sb1;
  logic signed [WIDTH-1:0] ma0, ma1, mb0, mb1, db;
  logic                    rev;

  assign dx_raw = $signed(x1) - $signed(x0);
  assign dy_raw = $signed(y1) - $signed(y0);
  assign abs_dx = dx_raw[WIDTH-1] ? -dx_raw : dx_raw;
  assign abs_dy = dy_raw[WIDTH-1] ? -dy_raw : dy_raw;
  assign steep  = abs_dy > abs_dx;

  // Swap into major/minor coordinates, then order by the major axis so
  // pixels always come out ascending regardless of command direction.
  assign sa0 = steep ? $signed(y0) : $signed(x0);
  assign sb0 = steep ? $signed(x0) : $signed(y0);
  assign sa1 = steep ? $signed(y1) : $signed(x1);
  assign sb1 = steep ? $signed(x1) : $signed(y1);
  assign rev = sa0 > sa1;

  assign ma0 = rev ? sa1 : sa0;
  assign ma1 = rev ? sa0 : sa1;
  assign mb0 = rev ? sb1 : sb0;
  assign mb1 = rev ? sb0 : sb1;
  assign db  = mb1 - mb0;

  assign x0_out = ma0;
  assign x1_out = ma1;
  assign y0_out = mb0;
  assign deltax = ma1 - ma0;
  assign deltay = db[WIDTH-1] ? -db : db;
  assign ystep  = (mb0 < mb1) ? YSTEP_POS : YSTEP_NEG;

endmodule

// File: rtl/line_raster_ctrl.sv
// Bresenham line sequencer: latches a command, captures the setup values,
// then steps the error accumulator emitting one pixel per accepted beat.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | capture precompute outputs, init counters and error
// DRAW  | present pixel, advance on pix_ready
module line_raster_ctrl
  import gfx_pkg::*;
#(
  parameter int WIDTH = GFX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             abort,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] py,
  output logic             line_done,
  output logic             busy
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      x0_in_q, x0_in_d, y0_in_q, y0_in_d;
  logic [WIDTH-1:0]      x1_in_q, x1_in_d, y1_in_q, y1_in_d;
  logic [WIDTH-1:0]      x1_q, x1_d, deltax_q, deltax_d, deltay_q, deltay_d;
  logic [WIDTH-1:0]      xc_q, xc_d, yc_q, yc_d;
  logic signed [1:0]     ystep_q, ystep_d;
  logic                  steep_q, steep_d;
  logic signed [WIDTH:0] err_q, err_d;
  logic                  line_done_q, line_done_d;

  logic [WIDTH-1:0]      pre_x0, pre_x1, pre_y0, pre_dx, pre_dy;
  logic signed [1:0]     pre_ystep;
  logic                  pre_steep;
  logic signed [WIDTH:0] err_init, err_step;

  Precomputed_param #(.WIDTH(WIDTH)) u_pre (
    .x0     (x0_in_q),
    .y0     (y0_in_q),
    .x1     (x1_in_q),
    .y1     (y1_in_q),
    .x0_out (pre_x0),
    .x1_out (pre_x1),
    .y0_out (pre_y0),
    .deltax (pre_dx),
    .deltay (pre_dy),
    .ystep  (pre_ystep),
    .steep  (pre_steep)
  );

  assign err_init = $signed({1'b0, pre_dx}) >>> 1;
  assign err_step = err_q - $signed({1'b0, deltay_q});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x0_in_q     <= '0;
      y0_in_q     <= '0;
      x1_in_q     <= '0;
      y1_in_q     <= '0;
      x1_q        <= '0;
      deltax_q    <= '0;
      deltay_q    <= '0;
      ystep_q     <= '0;
      steep_q     <= 1'b0;
      xc_q        <= '0;
      yc_q        <= '0;
      err_q       <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_in_q     <= x0_in_d;
      y0_in_q     <= y0_in_d;
      x1_in_q     <= x1_in_d;
      y1_in_q     <= y1_in_d;
      x1_q        <= x1_d;
      deltax_q    <= deltax_d;
      deltay_q    <= deltay_d;
      ystep_q     <= ystep_d;
      steep_q     <= steep_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      err_q       <= err_d;
      line_done_q <= line_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x0_in_d     = x0_in_q;
    y0_in_d     = y0_in_q;
    x1_in_d     = x1_in_q;
    y1_in_d     = y1_in_q;
    x1_d        = x1_q;
    deltax_d    = deltax_q;
    deltay_d    = deltay_q;
    ystep_d     = ystep_q;
    steep_d     = steep_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    err_d       = err_q;
    line_done_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            x0_in_d = x0;
            y0_in_d = y0;
            x1_in_d = x1;
            y1_in_d = y1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          x1_d     = pre_x1;
          deltax_d = pre_dx;
          deltay_d = pre_dy;
          ystep_d  = pre_ystep;
          steep_d  = pre_steep;
          xc_d     = pre_x0;
          yc_d     = pre_y0;
          err_d    = err_init;
          state_d  = DRAW;
        end
        DRAW: begin
          if (pix_ready) begin
            if (xc_q == x1_q) begin
              state_d     = IDLE;
              line_done_d = 1'b1;
            end else begin
              xc_d = xc_q + WIDTH'(1);
              if (err_step[WIDTH]) begin
                yc_d  = yc_q + {{(WIDTH-2){ystep_q[1]}}, ystep_q};
                err_d = err_step + $signed({1'b0, deltax_q});
              end else begin
                err_d = err_step;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE) && !abort;
  assign pix_valid = (state_q == DRAW);
  assign busy      = (state_q != IDLE);
  assign line_done = line_done_q;
  assign px        = steep_q ? yc_q : xc_q;
  assign py        = steep_q ? xc_q : yc_q;

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Bench for line_raster_ctrl: directed and random lines checked every cycle
// against a pixel-list model of the Bresenham walk.
module tb_line_raster_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         abort = 1'b0;
  logic         pix_ready = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         cmd_ready, pix_valid, line_done, busy;
  logic [W-1:0] px, py;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  line_raster_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .px        (px),
    .py        (py),
    .line_done (line_done),
    .busy      (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference walk: textbook Bresenham in plain integers, pixel list out.
  int gx[$], gy[$];
  function automatic void gen_line(input int ax0, input int ay0, input int ax1, input int ay1);
    int a0, b0, a1, b1, t, dx, dy, err, y, ys;
    bit st;
    gx.delete();
    gy.delete();
    st = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (st) begin a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1; end
    else    begin a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1; end
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    dx  = a1 - a0;
    dy  = iabs(b1 - b0);
    err = dx / 2;
    ys  = (b0 < b1) ? 1 : -1;
    y   = b0;
    for (int x = a0; x <= a1; x++) begin
      if (st) begin gx.push_back(y); gy.push_back(x); end
      else    begin gx.push_back(x); gy.push_back(y); end
      err -= dy;
      if (err < 0) begin
        y   += ys;
        err += dx;
      end
    end
  endfunction

  // Per-cycle checker with cycle-level model state
  int   mqx[$], mqy[$];
  bit   m_active = 1'b0;
  int   m_wait = 0;
  bit   m_done = 1'b0;
  bit   m_zero = 1'b1;
  bit   stall_prev = 1'b0;
  logic [W-1:0] prev_px, prev_py;

  always @(negedge clk) begin
    bit ev;
    ev = m_active && (m_wait == 0);
    chk("pix_valid", int'(pix_valid), int'(ev));
    chk("busy", int'(busy), int'(m_active));
    chk("cmd_ready", int'(cmd_ready), int'(!m_active && !abort));
    chk("line_done", int'(line_done), int'(m_done));
    if (ev && pix_valid && mqx.size() > 0) begin
      chk("px", int'(px), mqx[0] & 'h3ff);
      chk("py", int'(py), mqy[0] & 'h3ff);
    end
    if (stall_prev) begin
      chk("px_hold", int'(px), int'(prev_px));
      chk("py_hold", int'(py), int'(prev_py));
    end
    if (m_zero) begin
      chk("px_rst", int'(px), 0);
      chk("py_rst", int'(py), 0);
    end
    stall_prev = ev && !pix_ready && rst_n && !abort;
    prev_px = px;
    prev_py = py;
    m_done = 1'b0;
    m_zero = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0; m_wait = 0; mqx.delete(); mqy.delete(); m_zero = 1'b1;
    end else if (abort) begin
      m_active = 1'b0; m_wait = 0; mqx.delete(); mqy.delete();
    end else if (m_active) begin
      if (m_wait > 0) m_wait--;
      else if (pix_ready) begin
        void'(mqx.pop_front());
        void'(mqy.pop_front());
        if (mqx.size() == 0) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (cmd_valid) begin
      gen_line(int'($signed(x0)), int'($signed(y0)), int'($signed(x1)), int'($signed(y1)));
      mqx = gx;
      mqy = gy;
      m_active = 1'b1;
      m_wait = 1;
    end
  end

  // pix_ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random
  int rdy_mode = 0;
  int rdy_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = (rdy_cnt % 3 == 0);
      default: pix_ready = ($urandom_range(0, 1) == 1);
    endcase
    rdy_cnt++;
  end

  task automatic pin(input string nm, input int a, input int b, input int c, input int d,
                     input int n, input int ex[8], input int ey[8]);
    gen_line(a, b, c, d);
    chk({nm, "_len"}, gx.size(), n);
    for (int i = 0; i < n && i < gx.size(); i++)
      chk(nm, gx[i] * 1000 + gy[i], ex[i] * 1000 + ey[i]);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    x0 = a[W-1:0]; y0 = b[W-1:0]; x1 = c[W-1:0]; y1 = d[W-1:0];
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (line_done) begin seen = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    chk("line_done_seen", int'(seen), 1);
  endtask

  task automatic wait_beats(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      @(negedge clk);
      if (pix_valid && pix_ready) cnt++;
      @(posedge clk);
      #1;
    end
    chk("beat_wait", cnt, n);
  endtask

  initial begin
    int ex[8], ey[8];
    int a, b, c, d;

    ex = '{0, 1, 2, 3, 4, 5, 0, 0}; ey = '{0, 0, 1, 1, 2, 2, 0, 0};
    pin("pin_shallow", 0, 0, 5, 2, 6, ex, ey);
    pin("pin_reversed", 5, 2, 0, 0, 6, ex, ey);
    ex = '{0, 0, 1, 1, 0, 0, 0, 0}; ey = '{0, 1, 2, 3, 0, 0, 0, 0};
    pin("pin_steep", 0, 0, 1, 3, 4, ex, ey);
    ex = '{0, 1, 2, 3, 0, 0, 0, 0}; ey = '{3, 2, 1, 0, 0, 0, 0, 0};
    pin("pin_negstep", 0, 3, 3, 0, 4, ex, ey);
    ex = '{7, 0, 0, 0, 0, 0, 0, 0}; ey = '{7, 0, 0, 0, 0, 0, 0, 0};
    pin("pin_degenerate", 7, 7, 7, 7, 1, ex, ey);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 0;
    send(0, 0, 5, 2); wait_done();
    send(0, 0, 1, 3); wait_done();
    send(5, 2, 0, 0); wait_done();
    send(0, 3, 3, 0); wait_done();
    rdy_mode = 1;
    send(0, 0, 5, 2); wait_done();
    rdy_mode = 0;
    send(7, 7, 7, 7); wait_done();

    send(0, 0, 5, 2);
    wait_beats(3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    cmd_valid = 1'b1; abort = 1'b1;
    x0 = 10'd1; y0 = 10'd1; x1 = 10'd4; y1 = 10'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send(0, 0, 5, 2);
    wait_beats(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 200)) - 100;
      b = int'($urandom_range(0, 200)) - 100;
      c = int'($urandom_range(0, 200)) - 100;
      d = int'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 7) == 0) begin c = a; d = b; end
      send(a, b, c, d);
    end
    wait_done();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
